// File: rtl/duck_sprite_engine.sv
// Duck sprite stage: frame-rate motion/hit FSM plus a 2-cycle pixel pipeline
// that walks the sprite ROM in raster order and keys out the transparent colour.
module duck_sprite_engine #(
  parameter int          SPR_W      = 124,
  parameter int          SPR_H      = 162,
  parameter int          H_ACTIVE   = 640,
  parameter int          V_ACTIVE   = 480,
  parameter int          STEP_X     = 2,
  parameter int          STEP_Y     = 1,
  parameter int          FALL_STEP  = 4,
  parameter int          HIT_FRAMES = 30,
  parameter int          RESPAWN_Y  = 200,
  parameter logic [5:0]  KEY_COLOR  = 6'b110011,
  parameter logic [5:0]  BG_COLOR   = 6'b001011
) (
  input  logic        vga_clk,
  input  logic        reset,
  input  logic [9:0]  hcount,
  input  logic [9:0]  vcount,
  input  logic        shot,
  input  logic [5:0]  rom_data,
  output logic [14:0] rom_addr,
  output logic [5:0]  pixel_out,
  output logic [9:0]  duck_x,
  output logic [9:0]  duck_y,
  output logic [1:0]  duck_state
);

  localparam logic [1:0] FLY  = 2'd0;
  localparam logic [1:0] HIT  = 2'd1;
  localparam logic [1:0] FALL = 2'd2;

  localparam int          HW    = $clog2(HIT_FRAMES + 1);
  localparam logic [10:0] X_MAX = 11'(H_ACTIVE - SPR_W);
  localparam logic [10:0] Y_MAX = 11'(V_ACTIVE - SPR_H);
  localparam logic [10:0] SX    = 11'(STEP_X);
  localparam logic [10:0] SY    = 11'(STEP_Y);
  localparam logic [10:0] SF    = 11'(FALL_STEP);

  logic          frame_tick, in_box, active, take_hit;
  logic          dir_right, dir_up, shot_latch, landed, box_d1, act_d1;
  logic [HW-1:0] hit_cnt, ncnt;
  logic [10:0]   hc, vc, xw, yw;
  logic [9:0]    nx, ny;
  logic          nr, nu, nland;
  logic [1:0]    ns;

  assign hc = {1'b0, hcount};
  assign vc = {1'b0, vcount};
  assign xw = {1'b0, duck_x};
  assign yw = {1'b0, duck_y};

  assign frame_tick = (hcount == '0) && (vcount == 10'(V_ACTIVE));
  assign in_box = (xw <= hc) && (hc < xw + 11'(SPR_W)) &&
                  (yw <= vc) && (vc < yw + 11'(SPR_H));
  assign active = (hc < 11'(H_ACTIVE)) && (vc < 11'(V_ACTIVE));
  // A shot arriving on the tick itself still counts for that tick.
  assign take_hit = shot_latch || (shot && duck_state == FLY);

  always_comb begin
    nx    = duck_x;
    ny    = duck_y;
    nr    = dir_right;
    nu    = dir_up;
    ns    = duck_state;
    ncnt  = hit_cnt;
    nland = landed;
    case (duck_state)
      FLY: begin
        if (take_hit) begin
          ns   = HIT;
          ncnt = '0;
        end else begin
          if (dir_right) begin
            if (xw + SX >= X_MAX) begin nx = 10'(X_MAX); nr = 1'b0; end
            else nx = 10'(xw + SX);
          end else begin
            if (xw <= SX) begin nx = '0; nr = 1'b1; end
            else nx = 10'(xw - SX);
          end
          if (dir_up) begin
            if (yw <= SY) begin ny = '0; nu = 1'b0; end
            else ny = 10'(yw - SY);
          end else begin
            if (yw + SY >= Y_MAX) begin ny = 10'(Y_MAX); nu = 1'b1; end
            else ny = 10'(yw + SY);
          end
        end
      end
      HIT: begin
        ncnt = hit_cnt + HW'(1);
        if (hit_cnt == HW'(HIT_FRAMES - 1)) ns = FALL;
      end
      FALL: begin
        // Landing takes one tick clamped at the floor, then respawn on the next.
        if (landed) begin
          nx    = '0;
          ny    = 10'(RESPAWN_Y);
          nr    = 1'b1;
          nu    = 1'b1;
          ns    = FLY;
          nland = 1'b0;
        end else if (yw + SF < Y_MAX) begin
          ny = 10'(yw + SF);
        end else begin
          ny    = 10'(Y_MAX);
          nland = 1'b1;
        end
      end
      default: ns = FLY;
    endcase
  end

  always_ff @(posedge vga_clk or negedge reset) begin
    if (!reset) begin
      duck_x     <= '0;
      duck_y     <= 10'(RESPAWN_Y);
      dir_right  <= 1'b1;
      dir_up     <= 1'b1;
      duck_state <= FLY;
      hit_cnt    <= '0;
      landed     <= 1'b0;
      shot_latch <= 1'b0;
      rom_addr   <= '0;
      pixel_out  <= '0;
      box_d1     <= 1'b0;
      act_d1     <= 1'b0;
    end else begin
      if (frame_tick) begin
        duck_x     <= nx;
        duck_y     <= ny;
        dir_right  <= nr;
        dir_up     <= nu;
        duck_state <= ns;
        hit_cnt    <= ncnt;
        landed     <= nland;
        shot_latch <= 1'b0;
      end else if (shot && duck_state == FLY) begin
        shot_latch <= 1'b1;
      end
      box_d1 <= in_box;
      act_d1 <= active;
      // Row-major ROM + raster scan: counting in-box pixels yields the ROM index.
      if (frame_tick)  rom_addr <= '0;
      else if (box_d1) rom_addr <= rom_addr + 15'd1;
      if (!act_d1)                              pixel_out <= '0;
      else if (!box_d1 || rom_data == KEY_COLOR) pixel_out <= BG_COLOR;
      else                                      pixel_out <= rom_data;
    end
  end

endmodule

// File: tb/tb_duck_sprite_engine.sv
// Scoreboard bench for duck_sprite_engine: stimulus pushes expectations computed
// from a frame-level model; a negedge monitor pops and compares them.
module tb_duck_sprite_engine;
  localparam logic [5:0] KEY = 6'b110011;
  localparam logic [5:0] BG  = 6'b001011;

  logic        vga_clk = 1'b0;
  logic        reset = 1'b0;
  logic [9:0]  hcount = 10'd800;
  logic [9:0]  vcount = 10'd500;
  logic        shot = 1'b0;
  logic [5:0]  rom_data;
  logic [14:0] rom_addr;
  logic [5:0]  pixel_out;
  logic [9:0]  duck_x, duck_y;
  logic [1:0]  duck_state;

  always #5 vga_clk = ~vga_clk;

  function automatic logic [5:0] rom_fn(input logic [14:0] a);
    logic [5:0] r;
    if (a == 15'd5) return KEY;
    r = a[5:0] ^ a[11:6] ^ {3'b000, a[14:12]};
    if (r == KEY) r = r ^ 6'd1;
    return r;
  endfunction

  assign rom_data = rom_fn(rom_addr);

  duck_sprite_engine #(.HIT_FRAMES(30), .RESPAWN_Y(200)) dut (
    .vga_clk(vga_clk), .reset(reset), .hcount(hcount), .vcount(vcount),
    .shot(shot), .rom_data(rom_data), .rom_addr(rom_addr),
    .pixel_out(pixel_out), .duck_x(duck_x), .duck_y(duck_y),
    .duck_state(duck_state)
  );

  int cyc = 0;
  always @(posedge vga_clk) cyc <= cyc + 1;

  typedef struct {int due; int h; int v; logic [5:0] p;} pix_t;
  typedef struct {int due; logic [14:0] a;} addr_t;
  typedef struct {int due; int x; int y; int st;} pos_t;
  pix_t  pix_q[$];
  addr_t addr_q[$];
  pos_t  pos_q[$];
  int total = 0;
  int bad = 0;

  // Frame-level reference model
  int mx, my, mst, mhits;
  bit mright, mup, mpend, mland;

  task automatic model_reset();
    mx = 0; my = 200; mright = 1; mup = 1; mst = 0; mhits = 0; mpend = 0; mland = 0;
  endtask

  task automatic model_tick();
    bit hit;
    hit = mpend;
    mpend = 0;
    if (mst == 0) begin
      if (hit) begin
        mst = 1; mhits = 0;
      end else begin
        if (mright) begin
          if (mx + 2 >= 516) begin mx = 516; mright = 0; end else mx = mx + 2;
        end else begin
          if (mx <= 2) begin mx = 0; mright = 1; end else mx = mx - 2;
        end
        if (mup) begin
          if (my <= 1) begin my = 0; mup = 0; end else my = my - 1;
        end else begin
          if (my + 1 >= 318) begin my = 318; mup = 1; end else my = my + 1;
        end
      end
    end else if (mst == 1) begin
      mhits++;
      if (mhits == 30) mst = 2;
    end else begin
      if (mland) begin
        mx = 0; my = 200; mright = 1; mup = 1; mst = 0; mland = 0;
      end else if (my + 4 < 318) my = my + 4;
      else begin my = 318; mland = 1; end
    end
  endtask

  task automatic push_pos(input int due);
    pos_t e;
    e.due = due; e.x = mx; e.y = my; e.st = mst;
    pos_q.push_back(e);
  endtask

  task automatic push_pix(input int due, input int h, input int v, input logic [5:0] p);
    pix_t e;
    e.due = due; e.h = h; e.v = v; e.p = p;
    pix_q.push_back(e);
  endtask

  task automatic push_addr(input int due, input int a);
    addr_t e;
    e.due = due; e.a = 15'(a);
    addr_q.push_back(e);
  endtask

  task automatic drive(input int h, input int v, input bit s, input bit chk);
    bit act, box;
    int idx;
    logic [5:0] p;
    @(negedge vga_clk);
    hcount = 10'(h); vcount = 10'(v); shot = s;
    act = (h < 640) && (v < 480);
    box = (h >= mx) && (h < mx + 124) && (v >= my) && (v < my + 162);
    idx = (v - my) * 124 + (h - mx);
    if (chk) begin
      if (!act) p = '0;
      else if (!box) p = BG;
      else begin
        p = rom_fn(15'(idx));
        if (p == KEY) p = BG;
      end
      push_pix(cyc + 2, h, v, p);
      if (box) push_addr(cyc + 1, idx);
    end
    if (s && mst == 0) mpend = 1;
    if (h == 0 && v == 480) begin
      model_tick();
      push_pos(cyc + 1);
    end
  endtask

  task automatic tick(input bit s);
    drive(0, 480, s, 1);
    drive(800, 500, 0, 1);
  endtask

  task automatic sweep(input int rows);
    int x0, y0, vlo, vhi, hlo;
    x0 = mx; y0 = my;
    vlo = (y0 > 0) ? y0 - 1 : 0;
    vhi = (y0 + rows > 479) ? 479 : y0 + rows;
    hlo = (x0 > 0) ? x0 - 1 : 0;
    for (int v = vlo; v <= vhi; v++) begin
      for (int h = hlo; h <= x0 + 124; h++) drive(h, v, 0, 1);
      drive(639, v, 0, 1);
      drive(640, v, 0, 1);
      drive(1000, v, 0, 1);
    end
  endtask

  pix_t  mp;
  addr_t ma;
  pos_t  mo;

  always @(negedge vga_clk) begin
    while (pix_q.size() > 0 && pix_q[0].due <= cyc) begin
      mp = pix_q.pop_front();
      total++;
      if (mp.due != cyc || pixel_out !== mp.p) begin
        bad++;
        $display("FAIL pixel h=%0d v=%0d got=%b want=%b", mp.h, mp.v, pixel_out, mp.p);
      end
    end
    while (addr_q.size() > 0 && addr_q[0].due <= cyc) begin
      ma = addr_q.pop_front();
      total++;
      if (ma.due != cyc || rom_addr !== ma.a) begin
        bad++;
        $display("FAIL rom_addr cyc=%0d got=%0d want=%0d", cyc, rom_addr, ma.a);
      end
    end
    while (pos_q.size() > 0 && pos_q[0].due <= cyc) begin
      mo = pos_q.pop_front();
      total++;
      if (mo.due != cyc || duck_x !== 10'(mo.x) || duck_y !== 10'(mo.y) ||
          duck_state !== 2'(mo.st)) begin
        bad++;
        $display("FAIL position cyc=%0d got x=%0d y=%0d st=%0d want x=%0d y=%0d st=%0d",
                 cyc, duck_x, duck_y, duck_state, mo.x, mo.y, mo.st);
      end
    end
  end

  initial begin
    bit seen;
    model_reset();
    @(negedge vga_clk);
    push_pos(cyc + 1);
    push_addr(cyc + 1, 0);
    push_pix(cyc + 1, 800, 500, '0);
    drive(800, 500, 0, 1);
    drive(800, 500, 0, 1);
    reset = 1'b1;

    // Frame at (0,200), then first move
    sweep(162);
    tick(0);

    // Fly until the right wall bounce has happened and x is back to 514
    seen = 0;
    for (int k = 0; k < 400 && !(seen && mx == 514); k++) begin
      tick(0);
      if (mx == 516) seen = 1;
    end
    sweep(162);

    // Mid-frame shot, HIT with ignored shot, FALL with ignored shot
    drive(100, 50, 1, 1);
    tick(0);
    for (int k = 0; k < 30; k++) tick(k == 10);
    for (int k = 0; k < 100 && mst != 0; k++) tick(k == 3);

    // Shot coincident with the tick
    tick(1);
    for (int k = 0; k < 200 && mst != 0; k++) tick(0);

    // Asynchronous reset pulse mid-line, between clock edges
    tick(0);
    for (int i = 0; i < 10; i++) drive(mx + i, my, 0, i < 8);
    drive(mx + 10, my, 0, 0);
    #2 reset = 1'b0;
    #2 reset = 1'b1;
    model_reset();
    push_pos(cyc + 1);
    push_addr(cyc + 1, 0);
    push_pix(cyc + 1, mx + 10, my, '0);
    drive(800, 500, 0, 1);
    tick(0);
    sweep(2);

    repeat (5) @(negedge vga_clk);
    #1;
    if (pix_q.size() + addr_q.size() + pos_q.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain leftover=%0d want=0", pix_q.size() + addr_q.size() + pos_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
